// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit 7-segment display: SHOW/BLANK slot timing,
// digit MUX select, active-low anodes and frame-synchronous shadow data load.
module seg_scan_ctrl #(
    parameter int SHOW_CYC  = 50000,
    parameter int BLANK_CYC = 1000,
    parameter int CNT_W     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_data_0,
    input  logic [7:0] i_data_1,
    input  logic [7:0] i_data_2,
    input  logic [7:0] i_data_3,
    input  logic       i_load,
    output logic       o_busy,
    output logic       o_ack,
    output logic [7:0] o_data_0,
    output logic [7:0] o_data_1,
    output logic [7:0] o_data_2,
    output logic [7:0] o_data_3,
    output logic [1:0] o_ctrl,
    output logic [3:0] o_an,
    output logic       o_blank,
    output logic       o_frame
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        an_q, an_d;
    logic              blank_q, blank_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic [3:0][7:0]   stg_q, stg_d;
    logic [3:0][7:0]   data_q, data_d;
    logic              commit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                idx_d = 2'd0;
                cnt_d = '0;
                if (i_en) state_d = ST_SHOW;
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = (BLANK_CYC > 0) ? ST_BLANK : ST_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        if (!i_en) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end

        // Outputs are decoded from the next state so they change with it.
        an_d    = (state_d == ST_SHOW) ? ~(4'b0001 << idx_d) : 4'b1111;
        blank_d = (state_d != ST_SHOW);
        if (BLANK_CYC > 0)
            frame_d = (state_d == ST_BLANK) && (idx_d == 2'd0) && (cnt_d == BLANK_LAST);
        else
            frame_d = (state_d == ST_SHOW) && (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
    end

    // Commit and accept are mutually exclusive: one needs busy set, the other clear.
    assign commit = busy_q && ((state_q == ST_IDLE) || frame_q);

    always_comb begin
        busy_d = busy_q;
        ack_d  = 1'b0;
        stg_d  = stg_q;
        data_d = data_q;
        if (commit) begin
            data_d = stg_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
        end else if (i_load && !busy_q) begin
            stg_d  = {i_data_3, i_data_2, i_data_1, i_data_0};
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            an_q    <= 4'b1111;
            blank_q <= 1'b1;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            stg_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            blank_q <= blank_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            stg_q   <= stg_d;
            data_q  <= data_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_ack    = ack_q;
    assign o_data_0 = data_q[0];
    assign o_data_1 = data_q[1];
    assign o_data_2 = data_q[2];
    assign o_data_3 = data_q[3];
    assign o_ctrl   = idx_q;
    assign o_an     = an_q;
    assign o_blank  = blank_q;
    assign o_frame  = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (with and without blanking) checked
// every cycle against a position-in-frame arithmetic model.
module tb_seg_scan_ctrl;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst, en, load;
    logic [7:0] din [4];

    logic       busy  [2];
    logic       ack   [2];
    logic [7:0] d0 [2], d1 [2], d2 [2], d3 [2];
    logic [1:0] ctrl  [2];
    logic [3:0] an    [2];
    logic       blank [2];
    logic       frame [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.SHOW_CYC(S), .BLANK_CYC(2), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_data_0(din[0]), .i_data_1(din[1]), .i_data_2(din[2]), .i_data_3(din[3]),
        .i_load(load), .o_busy(busy[0]), .o_ack(ack[0]),
        .o_data_0(d0[0]), .o_data_1(d1[0]), .o_data_2(d2[0]), .o_data_3(d3[0]),
        .o_ctrl(ctrl[0]), .o_an(an[0]), .o_blank(blank[0]), .o_frame(frame[0])
    );

    seg_scan_ctrl #(.SHOW_CYC(S), .BLANK_CYC(0), .CNT_W(4)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_en(en),
        .i_data_0(din[0]), .i_data_1(din[1]), .i_data_2(din[2]), .i_data_3(din[3]),
        .i_load(load), .o_busy(busy[1]), .o_ack(ack[1]),
        .o_data_0(d0[1]), .o_data_1(d1[1]), .o_data_2(d2[1]), .o_data_3(d3[1]),
        .o_ctrl(ctrl[1]), .o_an(an[1]), .o_blank(blank[1]), .o_frame(frame[1])
    );

    // Reference model: running flag plus cycle position within the frame.
    bit         m_run  [2];
    int         m_p    [2];
    bit         m_busy [2];
    bit         m_ack  [2];
    logic [7:0] m_stg  [2][4];
    logic [7:0] m_dat  [2][4];

    function automatic int blank_len(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int period(input int k);
        return 4 * (S + blank_len(k));
    endfunction

    task automatic model_out(input int k, output logic [3:0] e_an, output logic e_blank,
                             output logic [1:0] e_ctrl, output logic e_frame);
        int slot, off, l;
        l = S + blank_len(k);
        if (!m_run[k]) begin
            e_an = 4'hF; e_blank = 1'b1; e_ctrl = 2'd0; e_frame = 1'b0;
        end else begin
            slot = (m_p[k] / l) % 4;
            off  = m_p[k] % l;
            if (off < S) begin
                e_an = ~(4'b0001 << slot); e_blank = 1'b0; e_ctrl = 2'(slot);
            end else begin
                e_an = 4'hF; e_blank = 1'b1; e_ctrl = 2'((slot + 1) % 4);
            end
            e_frame = (m_p[k] == period(k) - 1);
        end
    endtask

    task automatic model_edge(input int k);
        logic [3:0] e_an; logic e_blank; logic [1:0] e_ctrl; logic e_frame;
        bit commit;
        if (rst) begin
            m_run[k] = 0; m_p[k] = 0; m_busy[k] = 0; m_ack[k] = 0;
            for (int i = 0; i < 4; i++) begin m_stg[k][i] = 8'h0; m_dat[k][i] = 8'h0; end
        end else begin
            model_out(k, e_an, e_blank, e_ctrl, e_frame);
            commit = m_busy[k] && (!m_run[k] || e_frame);
            m_ack[k] = commit;
            if (commit) begin
                for (int i = 0; i < 4; i++) m_dat[k][i] = m_stg[k][i];
                m_busy[k] = 0;
            end else if (load && !m_busy[k]) begin
                for (int i = 0; i < 4; i++) m_stg[k][i] = din[i];
                m_busy[k] = 1;
            end
            if (!en) begin
                m_run[k] = 0; m_p[k] = 0;
            end else if (!m_run[k]) begin
                m_run[k] = 1; m_p[k] = 0;
            end else begin
                m_p[k] = (m_p[k] + 1) % period(k);
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    task automatic compare(input int k);
        logic [3:0] e_an; logic e_blank; logic [1:0] e_ctrl; logic e_frame;
        model_out(k, e_an, e_blank, e_ctrl, e_frame);
        chk("an",    k, 32'(an[k]),    32'(e_an));
        chk("blank", k, 32'(blank[k]), 32'(e_blank));
        chk("ctrl",  k, 32'(ctrl[k]),  32'(e_ctrl));
        chk("frame", k, 32'(frame[k]), 32'(e_frame));
        chk("busy",  k, 32'(busy[k]),  32'(m_busy[k]));
        chk("ack",   k, 32'(ack[k]),   32'(m_ack[k]));
        chk("data",  k, {d3[k], d2[k], d1[k], d0[k]},
            {m_dat[k][3], m_dat[k][2], m_dat[k][1], m_dat[k][0]});
    endtask

    task automatic step();
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    endtask

    initial begin
        logic [3:0] e_an; logic e_blank; logic [1:0] e_ctrl; logic e_frame;
        int guard;
        rst = 1'b1; en = 1'b0; load = 1'b0;
        set_data(8'h0, 8'h0, 8'h0, 8'h0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Free-running scan, two full frames
        en = 1'b1;
        repeat (50) step();

        // Load mid-frame, then a second load while busy that must be ignored
        set_data(8'd1, 8'd2, 8'd3, 8'd4); load = 1'b1;
        step();
        set_data(8'd9, 8'd9, 8'd9, 8'd9);
        step();
        load = 1'b0;
        repeat (40) step();

        // Load asserted on the frame-boundary cycle of the blanking instance
        guard = 0;
        model_out(0, e_an, e_blank, e_ctrl, e_frame);
        while (!e_frame && guard < 100) begin
            step(); guard++;
            model_out(0, e_an, e_blank, e_ctrl, e_frame);
        end
        set_data(8'hA5, 8'h5A, 8'h3C, 8'hC3); load = 1'b1;
        step();
        load = 1'b0;
        repeat (50) step();

        // Drop enable during SHOW of digit 2 with a load pending
        set_data(8'h11, 8'h22, 8'h33, 8'h44); load = 1'b1;
        step();
        load = 1'b0;
        guard = 0;
        model_out(0, e_an, e_blank, e_ctrl, e_frame);
        while (e_an != 4'b1011 && guard < 100) begin
            step(); guard++;
            model_out(0, e_an, e_blank, e_ctrl, e_frame);
        end
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (30) step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            en   = ($urandom_range(0, 99) < 97);
            load = ($urandom_range(0, 9) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
        end
        rst = 1'b0; en = 1'b1; load = 1'b0;
        repeat (10) step();

        // Reset mid-frame drops a pending load
        set_data(8'h77, 8'h66, 8'h55, 8'h44); load = 1'b1;
        step();
        load = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (30) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
